// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flushes,
// load-use interlock, operand forwarding select and a saturating stall counter.
module pipe_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        wb_valid,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        wb_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] stall_cnt_reg;

  logic memwait;
  logic mem_hold;
  logic load_use;

  assign memwait  = mem_valid & mem_req & ~mem_ack;
  assign mem_hold = memwait | (state_reg == S_ERR);

  assign load_use = id_valid & ex_valid & ex_is_load & ex_reg_write & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RUN;
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (if_stall && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_RUN: begin
        if (memwait) begin
          state_next    = S_WAIT;
          wait_cnt_next = 8'd0;
        end
      end
      S_WAIT: begin
        // A dropped request without ack leaves the access pending.
        if (mem_ack) begin
          state_next    = S_RUN;
          wait_cnt_next = 8'd0;
        end else if (memwait) begin
          if (wait_cnt_reg == WAIT_LAST)
            state_next = S_ERR;
          else
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      S_ERR:   state_next = S_ERR;
      default: state_next = S_RUN;
    endcase
  end

  // Priority: memory stall, then redirect flush, then load-use interlock.
  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    wb_bubble = 1'b0;
    if (!rst) begin
      if (mem_hold) begin
        if_stall  = 1'b1;
        id_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (load_use) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        id_flush = 1'b1;
      end
    end
  end

  logic [4:0] op_rs  [2];
  logic       op_use [2];
  logic [1:0] op_fwd [2];
  logic       ex_fwd_ok, mem_fwd_ok, wb_fwd_ok;

  assign op_rs[0]  = id_rs1;
  assign op_rs[1]  = id_rs2;
  assign op_use[0] = id_use_rs1;
  assign op_use[1] = id_use_rs2;

  // Load data is not available in EX, so a load there never forwards.
  assign ex_fwd_ok  = ex_valid & ex_reg_write & ~ex_is_load;
  assign mem_fwd_ok = mem_valid & mem_reg_write;
  assign wb_fwd_ok  = wb_valid & wb_reg_write;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign op_fwd[gi] = (!op_use[gi] || (op_rs[gi] == 5'd0))   ? 2'b00 :
                        (ex_fwd_ok  && (ex_rd  == op_rs[gi]))  ? 2'b01 :
                        (mem_fwd_ok && (mem_rd == op_rs[gi]))  ? 2'b10 :
                        (wb_fwd_ok  && (wb_rd  == op_rs[gi]))  ? 2'b11 : 2'b00;
  end

  assign fwd_a       = rst ? 2'b00 : op_fwd[0];
  assign fwd_b       = rst ? 2'b00 : op_fwd[1];
  assign mem_timeout = (state_reg == S_ERR);
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 16: data-memory wait cycles before timeout; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 id_valid  input  1  ID stage holds a valid instruction.
REQ-005 id_rs1, id_rs2  input  5 each  ID source register indices.
REQ-006 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-007 ex_valid, ex_reg_write, ex_is_load  input  1 each  EX stage valid / writes rd / is a load.
REQ-008 ex_rd  input  5  EX destination register.
REQ-009 ex_branch_taken  input  1  EX resolved a taken branch or jump (redirect).
REQ-010 mem_valid, mem_reg_write  input  1 each  MEM stage valid / writes rd.
REQ-011 mem_rd  input  5  MEM destination register.
REQ-012 mem_req, mem_ack  input  1 each  MEM data-memory request active / accepted this cycle.
REQ-013 wb_valid, wb_reg_write  input  1 each; wb_rd  input  5  WB stage destination.
REQ-014 if_stall, id_stall, ex_stall, mem_stall  output  1 each  hold the respective pipeline register.
REQ-015 if_flush, id_flush, wb_bubble  output  1 each  load a bubble into IF/ID, ID/EX, MEM/WB.
REQ-016 fwd_a, fwd_b  output  2 each  operand source for rs1/rs2: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-017 mem_timeout  output  1  sticky data-memory timeout flag.
REQ-018 stall_cnt  output  32  saturating count of cycles with if_stall=1.

Function
REQ-019 FSM states RUN, WAIT, ERR; internal wait_cnt 8 bits.
REQ-020 memwait = mem_valid & mem_req & ~mem_ack.
REQ-021 RUN -> WAIT when memwait; WAIT -> RUN when mem_ack (wait_cnt cleared); WAIT stays with wait_cnt+1 while memwait.
REQ-022 WAIT -> ERR when memwait and wait_cnt == MAX_WAIT-1; ERR is terminal until rst.
REQ-023 Memory stall = memwait or state==ERR: if/id/ex/mem_stall all 1, wb_bubble 1, if_flush=id_flush=0.
REQ-024 Ack cycle: mem_ack=1 releases all stalls combinationally in that same cycle; zero-wait access (req and ack same cycle) causes no stall.
REQ-025 Branch (no memory stall): ex_branch_taken=1 -> if_flush=1, id_flush=1, no stalls; load-use check suppressed.
REQ-026 Load-use: id_valid & ex_valid & ex_is_load & ex_reg_write & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) -> if_stall=1, id_stall=1, id_flush=1 for exactly one cycle.
REQ-027 Priority: memory stall > branch flush > load-use > run.
REQ-028 Forwarding per operand (x0 never forwarded; unused operand -> 00): EX match with ex_valid & ex_reg_write & ~ex_is_load -> 01; else MEM match with mem_valid & mem_reg_write -> 10; else WB match -> 11; else 00.
REQ-029 Forwarding outputs valid in all states; consumer ignores them during stalls.
REQ-030 mem_timeout = 1 iff state==ERR.
REQ-031 stall_cnt increments by 1 each cycle if_stall=1; holds at 0xFFFF_FFFF.

Reset
REQ-032 rst=1 at a clock edge: state RUN, wait_cnt 0, stall_cnt 0, mem_timeout 0, regardless of current state (incl. mid-WAIT, ERR).
REQ-033 While rst=1 all stall, flush, bubble outputs forced 0 and fwd_a/fwd_b forced 00.

Verification
REQ-034 Load-use: ex load rd=5, id_rs1=5 use=1 -> one cycle if_stall=id_stall=id_flush=1; next cycle (load in MEM) fwd_a=10, no stall; stall_cnt=1.
REQ-035 Forward priority: ex_rd=mem_rd=wb_rd=7, all writing, non-load, id_rs2=7 -> fwd_b=01; drop ex -> 10; drop mem -> 11; id_rs2=0 -> 00.
REQ-036 Memory wait: mem_req held, ack after 3 cycles -> all stalls 1 for 3 cycles, released on ack cycle, state RUN, mem_timeout 0.
REQ-037 Timeout: MAX_WAIT=4, never ack -> mem_timeout=1 after the 5th stalled cycle, stalls stay 1; rst pulse -> RUN, mem_timeout 0, stall_cnt 0.
REQ-038 Simultaneous: ex_branch_taken=1 with load-use match -> if_flush=id_flush=1, if_stall=0; same plus memwait -> stalls 1, flushes 0.
